// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// read/write encoding, default bus widths and latency counter width.
// Ports: none (package only).
package mem_pkg;

  // Default widths match the 6-bit MAR and the 16-bit MDR.
  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DATA_W = 16;

  // Wide enough for the largest legal latency (15).
  localparam int CNT_W = 4;

  // 4-phase handshake states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // RW strobe encoding as driven by the controller.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_array.sv
// Purpose: DEPTH x DATA_W word storage, cleared on reset.
// Latency: write commits on the clock edge; read is combinational from the address.
// Backpressure: none; one write and one read per cycle always accepted.
//
// Ports:
//   clk, rst   - clock and asynchronous active-high reset (clears every word)
//   i_we       - write enable, sampled on the rising edge
//   i_waddr    - write address; writes at or above DEPTH are dropped
//   i_wdata    - write data
//   i_raddr    - read address; reads at or above DEPTH return 0
//   o_rdata    - read data
module mem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Index width sized to the implemented depth, not the full address space,
  // so a shallow array is never indexed with surplus address bits.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_waddr_ok;
  logic w_raddr_ok;
  logic w_wr_en;

  assign w_waddr_ok = (int'(i_waddr) < DEPTH);
  assign w_raddr_ok = (int'(i_raddr) < DEPTH);
  assign w_wr_en    = i_we && w_waddr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = w_raddr_ok ? r_mem[i_raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/mem_responder.sv
// Purpose: memory-side responder for the controller's memEN/RW/MFC handshake.
// Latency: MFC rises LATENCY edges after the request is accepted; min LATENCY+2 cycles per access.
// Backpressure: master holds memEN until MFC; no new request until memEN is seen low.
//
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   memEN      - request strobe, held by the master until it sees MFC
//   RW         - 1 = read, 0 = write; latched at acceptance
//   addrIn     - word address from the MAR; latched at acceptance
//   dataIn     - write data from the MDR; latched at acceptance
//   dataOut    - registered read data; changes only on read completion or reset
//   MFC        - registered memory-function-complete level
//   busy       - high in BUSY and DONE (status only)
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memEN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              MFC,
  output logic              busy
);

  // Counter is loaded with LATENCY-1 so that completion lands LATENCY
  // edges after the accepting edge.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rw;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdat;
  logic [DATA_W-1:0]  r_dout;
  logic               r_mfc;
  logic               r_busy;

  logic               w_complete;
  logic               w_we;
  logic [DATA_W-1:0]  w_rdata;

  // Completion needs memEN still high: a drop on the final BUSY edge is an
  // abort, not a completed access.
  assign w_complete = (r_state == ST_BUSY) && memEN && (r_cnt == '0);
  assign w_we       = w_complete && (r_rw == RW_WRITE);

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (r_wdat),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rw    <= RW_WRITE;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_dout  <= '0;
      r_mfc   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (memEN) begin
            r_rw    <= RW;
            r_addr  <= addrIn;
            r_wdat  <= dataIn;
            r_cnt   <= CNT_INIT;
            r_state <= ST_BUSY;
            r_busy  <= 1'b1;
          end
        end

        ST_BUSY: begin
          if (!memEN) begin
            // Abort: nothing committed, dataOut left alone.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_mfc   <= 1'b1;
            if (r_rw == RW_READ) begin
              r_dout <= w_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          // Stay here while memEN is held so a held request cannot re-issue.
          if (!memEN) begin
            r_state <= ST_IDLE;
            r_mfc   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_mfc   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dataOut = r_dout;
  assign MFC     = r_mfc;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        memEN;
  logic        RW;
  logic [5:0]  addrIn;
  logic [15:0] dataIn;
  logic [15:0] dataOut;
  logic        MFC;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  mem_responder #(
    .ADDR_W  (6),
    .DATA_W  (16),
    .DEPTH   (32),
    .LATENCY (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .memEN   (memEN),
    .RW      (RW),
    .addrIn  (addrIn),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .MFC     (MFC),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Drives one full handshake starting at a negedge. lat = edges from the
  // accepting edge to MFC observed high (-1 if MFC never came), rd = dataOut
  // while MFC is high, mfc_after = MFC one edge after memEN is dropped.
  task automatic access(input logic rw, input logic [5:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output logic mfc_after);
    memEN  = 1'b1;
    RW     = rw;
    addrIn = a;
    dataIn = d;
    lat    = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (MFC === 1'b1) begin
        lat = i - 1;
        break;
      end
    end
    rd    = dataOut;
    memEN = 1'b0;
    @(negedge clk);
    mfc_after = MFC;
  endtask

  task automatic test_reset();
    rst = 1'b1; memEN = 1'b0; RW = 1'b0; addrIn = '0; dataIn = '0;
    #2;
    n_total++; if (MFC !== 1'b0) $display("FAIL reset_mfc got %b want 0", MFC); else n_pass++;
    n_total++; if (dataOut !== 16'h0000) $display("FAIL reset_dataout got %h want 0000", dataOut); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0 || MFC !== 1'b0)
      $display("FAIL idle_after_reset got busy=%b mfc=%b want 0/0", busy, MFC); else n_pass++;
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd; logic ma;
    access(1'b0, 6'd5, 16'hBEEF, lat, rd, ma);
    n_total++; if (lat !== 2) $display("FAIL wr5_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (ma !== 1'b0) $display("FAIL wr5_mfc_drop got %b want 0", ma); else n_pass++;
    access(1'b1, 6'd5, 16'h0000, lat, rd, ma);
    n_total++; if (lat !== 2) $display("FAIL rd5_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (rd !== 16'hBEEF) $display("FAIL rd5_data got %h want beef", rd); else n_pass++;
    n_total++; if (ma !== 1'b0) $display("FAIL rd5_mfc_drop got %b want 0", ma); else n_pass++;
    access(1'b0, 6'd6, 16'h0123, lat, rd, ma);
    n_total++; if (dataOut !== 16'hBEEF) $display("FAIL dataout_hold_on_write got %h want beef", dataOut); else n_pass++;
    access(1'b1, 6'd6, 16'h0000, lat, rd, ma);
    n_total++; if (rd !== 16'h0123 || lat !== 2)
      $display("FAIL rd6_back_to_back got %h lat %0d want 0123 lat 2", rd, lat); else n_pass++;
  endtask

  task automatic test_held_request();
    int lat; logic [15:0] rd; logic ma;
    memEN = 1'b1; RW = 1'b1; addrIn = 6'd5; dataIn = 16'h0000;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (MFC === 1'b1) begin lat = i - 1; break; end
    end
    n_total++; if (lat !== 2) $display("FAIL held_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (dataOut !== 16'hBEEF) $display("FAIL held_data got %h want beef", dataOut); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++; if (MFC !== 1'b1 || busy !== 1'b1)
        $display("FAIL held_mfc_cycle%0d got mfc=%b busy=%b want 1/1", k, MFC, busy); else n_pass++;
    end
    memEN = 1'b0;
    @(negedge clk);
    n_total++; if (MFC !== 1'b0 || busy !== 1'b0)
      $display("FAIL held_release got mfc=%b busy=%b want 0/0", MFC, busy); else n_pass++;
    access(1'b0, 6'd7, 16'h7777, lat, rd, ma);
    n_total++; if (lat !== 2) $display("FAIL held_next_latency got %0d want 2", lat); else n_pass++;
    access(1'b1, 6'd7, 16'h0000, lat, rd, ma);
    n_total++; if (rd !== 16'h7777) $display("FAIL held_next_data got %h want 7777", rd); else n_pass++;
  endtask

  task automatic test_abort();
    int lat; int mfc_seen; logic [15:0] rd; logic ma;
    access(1'b0, 6'd9, 16'h1234, lat, rd, ma);
    access(1'b1, 6'd5, 16'h0000, lat, rd, ma);
    mfc_seen = 0;
    memEN = 1'b1; RW = 1'b0; addrIn = 6'd9; dataIn = 16'hAAAA;
    @(negedge clk);
    if (MFC === 1'b1) mfc_seen++;
    @(negedge clk);
    if (MFC === 1'b1) mfc_seen++;
    // Dropped just before what would have been the completing edge.
    memEN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (MFC === 1'b1) mfc_seen++;
    end
    n_total++; if (mfc_seen !== 0) $display("FAIL abort_mfc got %0d high samples want 0", mfc_seen); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_total++; if (dataOut !== 16'hBEEF) $display("FAIL abort_dataout got %h want beef", dataOut); else n_pass++;
    access(1'b1, 6'd9, 16'h0000, lat, rd, ma);
    n_total++; if (rd !== 16'h1234) $display("FAIL abort_mem9 got %h want 1234", rd); else n_pass++;
  endtask

  task automatic test_field_change();
    int lat; logic [15:0] rd; logic ma;
    access(1'b0, 6'd3, 16'h3333, lat, rd, ma);
    access(1'b0, 6'd4, 16'h4444, lat, rd, ma);
    memEN = 1'b1; RW = 1'b1; addrIn = 6'd3; dataIn = 16'h0000;
    lat = -1;
    @(negedge clk);
    addrIn = 6'd4; RW = 1'b0; dataIn = 16'hDEAD;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (MFC === 1'b1) begin lat = i - 1; break; end
    end
    n_total++; if (lat !== 2) $display("FAIL field_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (dataOut !== 16'h3333) $display("FAIL field_read3 got %h want 3333", dataOut); else n_pass++;
    memEN = 1'b0;
    @(negedge clk);
    access(1'b1, 6'd4, 16'h0000, lat, rd, ma);
    n_total++; if (rd !== 16'h4444) $display("FAIL field_mem4 got %h want 4444", rd); else n_pass++;
  endtask

  task automatic test_out_of_range();
    int lat; logic [15:0] rd; logic ma;
    access(1'b0, 6'd8, 16'h0808, lat, rd, ma);
    access(1'b0, 6'd40, 16'h5555, lat, rd, ma);
    n_total++; if (lat !== 2) $display("FAIL oor_write_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (ma !== 1'b0) $display("FAIL oor_write_mfc_drop got %b want 0", ma); else n_pass++;
    access(1'b1, 6'd8, 16'h0000, lat, rd, ma);
    n_total++; if (rd !== 16'h0808) $display("FAIL oor_alias8 got %h want 0808", rd); else n_pass++;
    access(1'b1, 6'd40, 16'h0000, lat, rd, ma);
    n_total++; if (lat !== 2) $display("FAIL oor_read_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (rd !== 16'h0000) $display("FAIL oor_read_data got %h want 0000", rd); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [15:0] rd; logic ma;
    // Reset while in DONE with MFC high and dataOut holding a read value.
    memEN = 1'b1; RW = 1'b1; addrIn = 6'd5; dataIn = 16'h0000;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (MFC === 1'b1) begin lat = i - 1; break; end
    end
    n_total++; if (lat !== 2 || dataOut !== 16'hBEEF)
      $display("FAIL done_setup got lat %0d data %h want 2 beef", lat, dataOut); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (MFC !== 1'b0) $display("FAIL rst_done_mfc got %b want 0", MFC); else n_pass++;
    n_total++; if (dataOut !== 16'h0000) $display("FAIL rst_done_dataout got %h want 0000", dataOut); else n_pass++;
    memEN = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    // Reset while a write is in BUSY.
    memEN = 1'b1; RW = 1'b0; addrIn = 6'd1; dataIn = 16'hFFFF;
    @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL midwr_busy got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (MFC !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_midwr got mfc=%b busy=%b want 0/0", MFC, busy); else n_pass++;
    memEN = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    access(1'b1, 6'd1, 16'h0000, lat, rd, ma);
    n_total++; if (lat !== 2 || rd !== 16'h0000)
      $display("FAIL midwr_mem1 got %h lat %0d want 0000 lat 2", rd, lat); else n_pass++;
    access(1'b1, 6'd5, 16'h0000, lat, rd, ma);
    n_total++; if (rd !== 16'h0000) $display("FAIL rst_cleared_mem5 got %h want 0000", rd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_held_request();
    test_abort();
    test_field_change();
    test_out_of_range();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
